// File: rtl/sock_din_fifo_if.sv
// sock_din_fifo_if: groups the socket-side write stream and the DUT-side
// FWFT read stream of sock_din_fifo.
//   master : the environment (socket wrapper drives s_din*, DUT drives m_dout_ready)
//   slave  : the FIFO itself
interface sock_din_fifo_if #(
  parameter int DWIDTH = 64
);
  logic [DWIDTH-1:0] s_din;
  logic              s_din_valid;
  logic              s_din_ready;
  logic [DWIDTH-1:0] m_dout;
  logic              m_dout_valid;
  logic              m_dout_ready;

  modport master (
    output s_din, s_din_valid, m_dout_ready,
    input  s_din_ready, m_dout, m_dout_valid
  );

  modport slave (
    input  s_din, s_din_valid, m_dout_ready,
    output s_din_ready, m_dout, m_dout_valid
  );
endinterface

// File: rtl/sock_din_fifo.sv
// sock_din_fifo: elastic buffer between the socket server wrapper input
// stream and the DUT input. Registered backpressure on the socket side,
// first-word-fall-through presentation on the DUT side, plus occupancy and
// high-water-mark outputs for simulation debug.
//
// Optional feature: define SOCK_DIN_FIFO_BYPASS_EN to let a word arriving
// into an empty FIFO appear on m_dout in the same cycle (and be consumed
// there without touching memory when m_dout_ready is high). Without the
// macro, write-to-valid latency is one cycle and m_dout never depends
// combinationally on s_din.
module sock_din_fifo #(
  parameter  int DWIDTH = 64,
  parameter  int DEPTH  = 8,
  localparam int CWIDTH = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  sock_din_fifo_if.slave    bus,
  output logic [CWIDTH-1:0] level,
  output logic [CWIDTH-1:0] max_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CWIDTH-1:0] level_q;
  logic [CWIDTH-1:0] level_nxt;
  logic [CWIDTH-1:0] max_q;
  logic              rdy_q;
  logic              empty;
  logic              wr_en;
  logic              rd_en;

  // Occupancy after this cycle: write-only grows, read-only shrinks,
  // both or neither leave it unchanged.
  function automatic logic [CWIDTH-1:0] next_level(
    input logic [CWIDTH-1:0] cur,
    input logic              wr,
    input logic              rd
  );
    logic [CWIDTH-1:0] res;
    case ({wr, rd})
      2'b10:   res = cur + CWIDTH'(1);
      2'b01:   res = cur - CWIDTH'(1);
      default: res = cur;
    endcase
    return res;
  endfunction

  // High-water mark never decreases.
  function automatic logic [CWIDTH-1:0] hold_max(
    input logic [CWIDTH-1:0] cur_max,
    input logic [CWIDTH-1:0] lvl
  );
    return (lvl > cur_max) ? lvl : cur_max;
  endfunction

  assign empty = (level_q == '0);

`ifdef SOCK_DIN_FIFO_BYPASS_EN
  logic bypass;

  // An arriving word into an empty FIFO is shown directly; if the DUT takes
  // it in the same cycle it never enters memory.
  assign bypass           = empty && bus.s_din_valid && rdy_q && bus.m_dout_ready;
  assign wr_en            = bus.s_din_valid && rdy_q && !bypass;
  assign rd_en            = !empty && bus.m_dout_ready;
  assign bus.m_dout_valid = empty ? (bus.s_din_valid && rdy_q) : 1'b1;
  assign bus.m_dout       = empty ? bus.s_din : mem[rd_ptr];
`else
  assign wr_en            = bus.s_din_valid && rdy_q;
  assign rd_en            = !empty && bus.m_dout_ready;
  assign bus.m_dout_valid = !empty;
  assign bus.m_dout       = mem[rd_ptr];
`endif

  assign level_nxt       = next_level(level_q, wr_en, rd_en);
  assign bus.s_din_ready = rdy_q;
  assign level           = level_q;
  assign max_level       = max_q;

  // Storage array: data path only, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.s_din;
    end
  end

  // Pointers, occupancy, high-water mark and registered ready. Ready is
  // derived from the next occupancy only, so a read while full frees the
  // slot one cycle later and m_dout_ready never reaches s_din_ready
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      max_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level_q <= level_nxt;
      max_q   <= hold_max(max_q, level_nxt);
      rdy_q   <= (level_nxt < CWIDTH'(DEPTH));
    end
  end

endmodule

// File: tb/tb_sock_din_fifo.sv
// tb_sock_din_fifo: directed scenarios for sock_din_fifo in its default
// (no bypass) build, DWIDTH=64, DEPTH=8.
module tb_sock_din_fifo;

  localparam int DW = 64;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] level;
  logic [CW-1:0] max_level;

  int n_cmp = 0;
  int n_bad = 0;

  sock_din_fifo_if #(.DWIDTH(DW)) bus ();

  sock_din_fifo #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .level     (level),
    .max_level (max_level)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #99;
    n_cmp++; if (bus.s_din_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_during: got %b want 0", bus.s_din_ready); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL rst_level_during: got %0d want 0", level); end
    n_cmp++; if (bus.m_dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid_during: got %b want 0", bus.m_dout_valid); end
    n_cmp++; if (max_level !== 4'd0) begin n_bad++; $display("FAIL rst_max_during: got %0d want 0", max_level); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.s_din_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_before_edge: got %b want 0", bus.s_din_ready); end
    @(negedge clk);
    n_cmp++; if (bus.s_din_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", bus.s_din_ready); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL rst_level_after: got %0d want 0", level); end
    n_cmp++; if (bus.m_dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid_after: got %b want 0", bus.m_dout_valid); end
    n_cmp++; if (max_level !== 4'd0) begin n_bad++; $display("FAIL rst_max_after: got %0d want 0", max_level); end
  endtask

  task automatic test_single_word();
    bus.s_din        = 64'h0000_0002_0000_0003;
    bus.s_din_valid  = 1'b1;
    bus.m_dout_ready = 1'b1;
    @(negedge clk);
    bus.s_din_valid = 1'b0;
    n_cmp++; if (bus.m_dout_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", bus.m_dout_valid); end
    n_cmp++; if (bus.m_dout !== 64'h0000_0002_0000_0003) begin n_bad++; $display("FAIL single_data: got %h want 0000000200000003", bus.m_dout); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level1: got %0d want 1", level); end
    @(negedge clk);
    n_cmp++; if (bus.m_dout_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", bus.m_dout_valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL single_level0: got %0d want 0", level); end
    n_cmp++; if (max_level !== 4'd1) begin n_bad++; $display("FAIL single_max: got %0d want 1", max_level); end
  endtask

  task automatic test_fill();
    bus.m_dout_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.s_din       = 64'(i);
      bus.s_din_valid = 1'b1;
      n_cmp++; if (bus.s_din_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_w%0d: got %b want 1", i, bus.s_din_ready); end
      @(negedge clk);
    end
    bus.s_din = 64'd9;
    n_cmp++; if (bus.s_din_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", bus.s_din_ready); end
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL full_level: got %0d want 8", level); end
    n_cmp++; if (max_level !== 4'd8) begin n_bad++; $display("FAIL full_max: got %0d want 8", max_level); end
    n_cmp++; if (bus.m_dout_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", bus.m_dout_valid); end
    n_cmp++; if (bus.m_dout !== 64'd1) begin n_bad++; $display("FAIL full_head: got %0d want 1", bus.m_dout); end
    @(negedge clk);
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL full_hold_level: got %0d want 8", level); end
    n_cmp++; if (bus.s_din_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold_ready: got %b want 0", bus.s_din_ready); end
  endtask

  task automatic test_drain();
    int exp_w = 1;
    int nxt_w = 9;
    int rise  = -1;
    logic acc;
    bus.m_dout_ready = 1'b1;
    for (int c = 0; c < 30 && exp_w <= 10; c++) begin
      n_cmp++; if (bus.m_dout_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid_c%0d: got %b want 1", c, bus.m_dout_valid); end
      n_cmp++; if (bus.m_dout !== 64'(exp_w)) begin n_bad++; $display("FAIL drain_data_c%0d: got %0d want %0d", c, bus.m_dout, exp_w); end
      exp_w++;
      acc = bus.s_din_valid && bus.s_din_ready;
      if (rise < 0 && bus.s_din_ready) rise = c;
      @(negedge clk);
      if (acc) begin
        nxt_w++;
        if (nxt_w > 10) bus.s_din_valid = 1'b0;
        else bus.s_din = 64'(nxt_w);
      end
    end
    n_cmp++; if (exp_w !== 11) begin n_bad++; $display("FAIL drain_count: got %0d words want 10", exp_w - 1); end
    n_cmp++; if (rise !== 1) begin n_bad++; $display("FAIL drain_ready_rise: got cycle %0d want 1", rise); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL drain_level: got %0d want 0", level); end
    n_cmp++; if (bus.m_dout_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid_end: got %b want 0", bus.m_dout_valid); end
    n_cmp++; if (max_level !== 4'd8) begin n_bad++; $display("FAIL drain_max: got %0d want 8", max_level); end
    n_cmp++; if (bus.s_din_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready_end: got %b want 1", bus.s_din_ready); end
  endtask

  task automatic test_stream_wrap();
    bus.s_din_valid  = 1'b0;
    bus.m_dout_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.s_din        = 64'd0;
    bus.s_din_valid  = 1'b1;
    bus.m_dout_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.m_dout_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid_k%0d: got %b want 1", k, bus.m_dout_valid); end
      n_cmp++; if (bus.m_dout !== 64'(k - 1)) begin n_bad++; $display("FAIL stream_data_k%0d: got %0d want %0d", k, bus.m_dout, k - 1); end
      n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL stream_level_k%0d: got %0d want 1", k, level); end
      n_cmp++; if (bus.s_din_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready_k%0d: got %b want 1", k, bus.s_din_ready); end
      if (k < 40) bus.s_din = 64'(k);
      else bus.s_din_valid = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (bus.m_dout_valid !== 1'b0) begin n_bad++; $display("FAIL stream_valid_end: got %b want 0", bus.m_dout_valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL stream_level_end: got %0d want 0", level); end
    n_cmp++; if (max_level !== 4'd1) begin n_bad++; $display("FAIL stream_max: got %0d want 1", max_level); end
  endtask

  task automatic test_reset_mid();
    bus.m_dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_din       = 64'hA0 + 64'(i);
      bus.s_din_valid = 1'b1;
      @(negedge clk);
    end
    bus.s_din_valid = 1'b0;
    n_cmp++; if (level !== 4'd5) begin n_bad++; $display("FAIL mid_level_pre: got %0d want 5", level); end
    n_cmp++; if (max_level !== 4'd5) begin n_bad++; $display("FAIL mid_max_pre: got %0d want 5", max_level); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.m_dout_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid_async: got %b want 0", bus.m_dout_valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL mid_level_async: got %0d want 0", level); end
    n_cmp++; if (max_level !== 4'd0) begin n_bad++; $display("FAIL mid_max_async: got %0d want 0", max_level); end
    n_cmp++; if (bus.s_din_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_async: got %b want 0", bus.s_din_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.s_din       = 64'hBEEF;
    bus.s_din_valid = 1'b1;
    @(negedge clk);
    bus.s_din_valid = 1'b0;
    n_cmp++; if (bus.m_dout_valid !== 1'b1) begin n_bad++; $display("FAIL mid_new_valid: got %b want 1", bus.m_dout_valid); end
    n_cmp++; if (bus.m_dout !== 64'hBEEF) begin n_bad++; $display("FAIL mid_new_data: got %h want beef", bus.m_dout); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL mid_new_level: got %0d want 1", level); end
    bus.m_dout_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.m_dout_valid !== 1'b0) begin n_bad++; $display("FAIL mid_drained_valid: got %b want 0", bus.m_dout_valid); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL mid_drained_level: got %0d want 0", level); end
  endtask

  initial begin
    bus.s_din        = '0;
    bus.s_din_valid  = 1'b0;
    bus.m_dout_ready = 1'b0;
    test_reset();
    test_single_word();
    test_fill();
    test_drain();
    test_stream_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sock_din_fifo.md
Name: sock_din_fifo

Overview:
Elastic buffer between the socket server wrapper's input stream (socket_din/socket_din_valid/socket_din_ready) and the DUT input. It absorbs socket bursts and applies real backpressure to the socket via socket_din_ready. It presents a first-word-fall-through valid/ready stream to the DUT. It also reports occupancy and a high-water mark for simulation debug.

Parameters:
DWIDTH, 64, data width in bits; matches the wrapper's DWIDTH_IN.
DEPTH, 8, number of entries; power of 2, minimum 2.
CWIDTH, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
clk  input  1  single clock
rst  input  1  asynchronous reset, active-high
s_din  input  DWIDTH  write data from socket_din
s_din_valid  input  1  write request from socket_din_valid
s_din_ready  output  1  drives socket_din_ready; space available
m_dout  output  DWIDTH  head-of-queue data to the DUT (e.g. {din1,din0})
m_dout_valid  output  1  head entry valid
m_dout_ready  input  1  DUT accepts head entry
level  output  CWIDTH  current occupancy, 0..DEPTH
max_level  output  CWIDTH  highest occupancy seen since reset

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, level=0, max_level=0, m_dout_valid=0, s_din_ready=0 while rst is high. Memory contents are not reset. m_dout is don't-care while m_dout_valid=0.
- s_din_ready is registered: 1 iff level<DEPTH after the current cycle's update. It is first 1 in the cycle after rst deasserts. There is no combinational path from m_dout_ready to s_din_ready.
- Write: occurs when s_din_valid && s_din_ready. mem[wr_ptr] <= s_din; wr_ptr increments modulo DEPTH.
- Read: occurs when m_dout_valid && m_dout_ready. rd_ptr increments modulo DEPTH.
- Presentation: m_dout = mem[rd_ptr] (FWFT); m_dout_valid = (level!=0).
- Default build latency: a word written at edge N is visible on m_dout/m_dout_valid after edge N, i.e. 1 cycle write-to-valid.
- level update: +1 on write only, -1 on read only, unchanged on simultaneous write+read or neither.
- Full (level==DEPTH): s_din_ready=0. A read in the same cycle does not enable a write that cycle; s_din_ready rises the next cycle.
- Empty (level==0): m_dout_valid=0, so m_dout_ready is ignored and no underflow is possible. Write+read cannot coincide unless the optional feature is enabled.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Ordering is strictly FIFO across the wrap.
- max_level <= max(max_level, next level) every cycle; it never decreases until reset.
- Protocol rules: s_din must be held while s_din_valid && !s_din_ready. The DUT may hold m_dout_ready high constantly; that is legal.
- Reset mid-operation: all buffered entries are discarded immediately and outputs take their reset values asynchronously.

Optional Feature:
Macro SOCK_DIN_FIFO_BYPASS_EN.
- Defined: when level==0 and s_din_valid && m_dout_ready, s_din passes combinationally to m_dout with m_dout_valid=1. The word is consumed in the same cycle and is not written to memory; level stays 0 and pointers do not move.
- Defined, empty and m_dout_ready=0: m_dout_valid = s_din_valid, m_dout = s_din, and the word is also written to memory as normal.
- Not defined: no bypass. Minimum latency is 1 cycle and m_dout never depends combinationally on s_din.

Test Plan:
1. Reset release: hold rst 100ns, then release -> s_din_ready=0 during reset, 1 on the first clk after; level=0, m_dout_valid=0, max_level=0.
2. Single word: s_din=64'h0000_0002_0000_0003 for 1 cycle, m_dout_ready=1 -> next cycle m_dout_valid=1 with that data for 1 cycle, level 1->0. With BYPASS_EN: valid in the same cycle, level stays 0.
3. Fill to full: m_dout_ready=0, write 10 words (1..10) back-to-back -> words 1..8 accepted, s_din_ready=0 after the 8th, level=8, max_level=8, words 9..10 held.
4. Drain while full: continuing from scenario 3, assert m_dout_ready -> outputs 1,2,...,10 in order; s_din_ready rises 1 cycle after the first read; no word lost or duplicated.
5. Streaming wrap: valid and ready both held high for 40 words (values 0..39) -> in-order output, pointers wrap 5 times, level steady at 1 (0 with BYPASS_EN), max_level<=1.
6. Reset mid-burst: level=5, assert rst asynchronously between edges -> m_dout_valid=0, level=0, max_level=0 immediately; after release the first new word written is the first output.
